// File: rtl/cache_line_arbiter.sv
// Shares the single physical-memory line port between the I-cache and the D-cache.
// D has priority; a bounded D streak guarantees that a waiting I fetch is eventually granted.
module cache_line_arbiter #(
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

  logic [1:0]        r_state;
  logic [SW-1:0]     r_streak;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [31:0]       r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_streak_full;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req       = i_read;
  assign w_d_req       = d_read | d_write;
  assign w_streak_full = (r_streak == STREAK_MAX);
  // A waiting I only overtakes D once D has used up its streak allowance.
  assign w_grant_i     = (r_state == ST_IDLE) && w_i_req && (!w_d_req || w_streak_full);
  assign w_grant_d     = (r_state == ST_IDLE) && w_d_req && !(w_i_req && w_streak_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_streak       <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            r_state        <= ST_SERVE_I;
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= i_address;
            r_streak       <= '0;
          end else if (w_grant_d) begin
            r_state        <= ST_SERVE_D;
            r_pmem_address <= d_address;
            // An illegal read+write request is treated as a writeback.
            if (d_write) begin
              r_pmem_write <= 1'b1;
              r_pmem_read  <= 1'b0;
              r_pmem_wdata <= d_wdata;
            end else begin
              r_pmem_write <= 1'b0;
              r_pmem_read  <= 1'b1;
            end
            if (!w_i_req)
              r_streak <= '0;
            else if (!w_streak_full)
              r_streak <= r_streak + SW'(1);
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_resp       = (r_state == ST_SERVE_I) && pmem_resp;
  assign d_resp       = (r_state == ST_SERVE_D) && pmem_resp;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign busy         = (r_state != ST_IDLE);
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Bench for cache_line_arbiter: directed scenarios plus randomized rounds checked
// against a transaction-level model of pending requests, grant priority and streak.
module tb_cache_line_arbiter;

  localparam int LW  = 256;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;

  cache_line_arbiter #(.LINE_W(LW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: outstanding requests, consecutive D grants while I waits, last written line.
  bit            m_i_pend, m_d_pend, m_d_wr;
  logic [31:0]   m_i_addr, m_d_addr;
  logic [LW-1:0] m_d_wdata, m_wdata_last;
  int            m_streak;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_reqs();
    i_read    = m_i_pend;
    i_address = m_i_addr;
    d_read    = m_d_pend && !m_d_wr;
    d_write   = m_d_pend && m_d_wr;
    d_address = m_d_addr;
    d_wdata   = m_d_wdata;
  endtask

  // Entered at the falling edge of an IDLE cycle; leaves at the falling edge of the next IDLE cycle.
  task automatic round(input bit ri, input bit rd, input bit dw, input bit both,
                       input logic [31:0] ai, input logic [31:0] ad, input logic [LW-1:0] wd,
                       input int lat, input bit stale);
    logic [7:0]  g;
    logic [31:0] e_addr;
    bit          e_rd, e_wr;
    if (ri && !m_i_pend) begin m_i_pend = 1; m_i_addr = ai; end
    if (rd && !m_d_pend) begin m_d_pend = 1; m_d_wr = dw; m_d_addr = ad; m_d_wdata = wd; end
    drive_reqs();
    if (rd && both && m_d_wr) d_read = 1'b1;
    if (!m_i_pend && !m_d_pend) begin
      pmem_resp  = 1'b1;
      pmem_rdata = rand_line();
      #1;
      chk("idle_spur_iresp", i_resp, 0);
      chk("idle_spur_dresp", d_resp, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      chk("idle_stay_busy", busy, 0);
      chk("idle_stay_rd", pmem_read, 0);
      chk("idle_stay_wr", pmem_write, 0);
      return;
    end
    if (m_i_pend && m_d_pend && m_streak == MAX) g = "I";
    else if (m_d_pend) g = "D";
    else g = "I";
    if (g == "I") begin
      m_streak = 0;
      e_addr = m_i_addr; e_rd = 1; e_wr = 0;
    end else begin
      m_streak = m_i_pend ? ((m_streak < MAX) ? m_streak + 1 : m_streak) : 0;
      e_addr = m_d_addr; e_wr = m_d_wr; e_rd = !m_d_wr;
      if (m_d_wr) m_wdata_last = m_d_wdata;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) begin
        pmem_rdata = rand_line();
        pmem_resp  = 1'b1;
      end
      #1;
      chk("serve_rd", pmem_read, e_rd);
      chk("serve_wr", pmem_write, e_wr);
      chk("serve_addr", pmem_address, e_addr);
      chk("serve_wdata", pmem_wdata, m_wdata_last);
      chk("serve_busy", busy, 1);
      chk("i_resp", i_resp, (g == "I") && (c == lat));
      chk("d_resp", d_resp, (g == "D") && (c == lat));
      if (c == lat) begin
        chk("i_rdata", i_rdata, pmem_rdata);
        chk("d_rdata", d_rdata, pmem_rdata);
      end
    end
    @(negedge clk);
    pmem_resp = 1'($urandom_range(0, 1));
    if (g == "I") m_i_pend = 0; else m_d_pend = 0;
    if (!(stale && g == "D")) drive_reqs();
    #1;
    chk("done_busy", busy, 1);
    chk("done_rd", pmem_read, 0);
    chk("done_wr", pmem_write, 0);
    chk("done_iresp", i_resp, 0);
    chk("done_dresp", d_resp, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    drive_reqs();
    #1;
    chk("back_idle_busy", busy, 0);
    chk("back_idle_rd", pmem_read, 0);
    chk("back_idle_wr", pmem_write, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    m_i_pend = 0; m_d_pend = 0; m_d_wr = 0; m_i_addr = '0; m_d_addr = '0;
    m_d_wdata = '0; m_wdata_last = '0; m_streak = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_rd", pmem_read, 0);
    chk("rst_wr", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iresp", i_resp, 0);
    chk("rst_dresp", d_resp, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // single I read at 0x60, memory latency 3
    round(1, 0, 0, 0, 32'h0000_0060, '0, '0, 3, 0);
    // simultaneous I read and D writeback: D first, then I
    round(1, 1, 1, 0, 32'h0000_0080, 32'h0000_1000, {32{8'hA5}}, 2, 0);
    round(0, 0, 0, 0, '0, '0, '0, 1, 0);
    // starvation bound: I held, D re-requests every transaction
    for (int k = 0; k < 6; k++)
      round(1, 1, k[0], 0, 32'h0000_2000, 32'h0000_3000 + 32'(k * 32), rand_line(), 1 + k % 3, 0);
    round(0, 0, 0, 0, '0, '0, '0, 2, 0);
    // stale D request kept high through DONE, then dropped in IDLE
    round(0, 1, 0, 0, '0, 32'h0000_4000, '0, 1, 1);
    round(0, 0, 0, 0, '0, '0, '0, 1, 0);

    // reset in the same cycle as pmem_resp during SERVE_D
    d_read = 1'b1; d_address = 32'h0000_5000;
    @(negedge clk);
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    chk("rstresp_dresp", d_resp, 1);
    chk("rstresp_iresp", i_resp, 0);
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b0; d_read = 1'b0;
    m_streak = 0; m_wdata_last = '0;
    #1;
    chk("rstresp_busy", busy, 0);
    chk("rstresp_rd", pmem_read, 0);

    // build a D streak of 3 with I waiting, then reset mid SERVE_D
    for (int k = 0; k < 3; k++)
      round(1, 1, 1, 0, 32'h0000_6000, 32'h0000_7000, rand_line(), 2, 0);
    m_d_pend = 1; m_d_wr = 0; m_d_addr = 32'h0000_8000;
    drive_reqs();
    @(negedge clk);
    #1;
    chk("rstmid_rd_c1", pmem_read, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_rd_c2", pmem_read, 1);
    @(negedge clk);
    rst = 1'b0;
    m_d_pend = 0; m_streak = 0; m_wdata_last = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("rstmid_rd", pmem_read, 0);
    chk("rstmid_wr", pmem_write, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_late_dresp", d_resp, 0);
    chk("rstmid_wdata", pmem_wdata, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("rstmid_idle", busy, 0);
    // streak must start from 0 again: four D grants before the waiting I
    for (int k = 0; k < 6; k++)
      round(1, 1, 0, 0, 32'h0000_9000, 32'h0000_A000 + 32'(k * 32), '0, 1, 0);
    round(0, 0, 0, 0, '0, '0, '0, 1, 0);

    for (int k = 0; k < 250; k++)
      round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), $urandom, $urandom, rand_line(),
            int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
